// File: rtl/delay_pkg.sv
// Shared types and sizing helpers for the random-delay stage and the light-sequencing fsm.
package delay_pkg;

    typedef enum logic [1:0] {IDLE, COUNT, DONE} delay_state_t;

    // Counter width: one extra bit so rnd + OFFSET never wraps.
    function automatic int unsigned cnt_w(input int unsigned width);
        return width + 1;
    endfunction

endpackage

// File: rtl/edge_rise.sv
// Rising-edge detector. The delayed copy resets high, so a level held through reset does not
// produce an edge.
module edge_rise (
    input  logic clk_i,
    input  logic rst_i,
    input  logic din_i,
    output logic rise_o
);

    logic din_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            din_q <= 1'b1;
        end else begin
            din_q <= din_i;
        end
    end

    assign rise_o = din_i & ~din_q;

endmodule

// File: rtl/random_delay.sv
// Random hold before lights-out: loads rnd + OFFSET, counts timebase ticks down to zero, then
// pulses time_out_o. Advances the lfsr once per delay started.
module random_delay
    import delay_pkg::*;
#(
    parameter int unsigned WIDTH  = 4,
    parameter int unsigned OFFSET = 1
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     tick_i,
    input  logic                     trigger_i,
    input  logic                     cancel_i,
    input  logic [WIDTH-1:0]         rnd_i,
    output logic                     lfsr_en_o,
    output logic                     busy_o,
    output logic                     time_out_o,
    output logic [cnt_w(WIDTH)-1:0]  delay_val_o
);

    localparam int unsigned CntW = cnt_w(WIDTH);

    delay_state_t    state_q;
    logic [CntW-1:0] cnt_q;
    logic [CntW-1:0] delay_val_q;
    logic [CntW-1:0] load_val;
    logic            lfsr_en_q;
    logic            busy_q;
    logic            time_out_q;
    logic            start;

    edge_rise u_edge_rise (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .din_i  (trigger_i),
        .rise_o (start)
    );

    assign load_val = CntW'(rnd_i) + CntW'(OFFSET);

    // Outputs are registered alongside the state so they track it cycle for cycle.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            delay_val_q <= '0;
            lfsr_en_q   <= 1'b0;
            busy_q      <= 1'b0;
            time_out_q  <= 1'b0;
        end else begin
            lfsr_en_q  <= 1'b0;
            time_out_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (start) begin
                        cnt_q       <= load_val;
                        delay_val_q <= load_val;
                        lfsr_en_q   <= 1'b1;
                        busy_q      <= 1'b1;
                        state_q     <= COUNT;
                    end
                end
                COUNT: begin
                    if (cancel_i) begin
                        cnt_q   <= '0;
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end else if (cnt_q == '0) begin
                        time_out_q <= 1'b1;
                        state_q    <= DONE;
                    end else if (tick_i) begin
                        if (cnt_q == CntW'(1)) begin
                            cnt_q      <= '0;
                            time_out_q <= 1'b1;
                            state_q    <= DONE;
                        end else begin
                            cnt_q <= cnt_q - CntW'(1);
                        end
                    end
                end
                DONE: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign lfsr_en_o   = lfsr_en_q;
    assign busy_o      = busy_q;
    assign time_out_o  = time_out_q;
    assign delay_val_o = delay_val_q;

endmodule

// File: tb/tb_random_delay.sv
// Directed bench for random_delay: one OFFSET=1 instance and one OFFSET=0 instance.
module tb_random_delay;

    logic       clk;
    logic       rst;
    logic       tick, trigger, cancel;
    logic [3:0] rnd;
    logic       lfsr_en, busy, time_out;
    logic [4:0] delay_val;
    logic       tick0, trigger0, cancel0;
    logic [3:0] rnd0;
    logic       lfsr_en0, busy0, time_out0;
    logic [4:0] delay_val0;

    int vectors;
    int miscompares;

    random_delay #(.WIDTH(4), .OFFSET(1)) u_dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .tick_i      (tick),
        .trigger_i   (trigger),
        .cancel_i    (cancel),
        .rnd_i       (rnd),
        .lfsr_en_o   (lfsr_en),
        .busy_o      (busy),
        .time_out_o  (time_out),
        .delay_val_o (delay_val)
    );

    random_delay #(.WIDTH(4), .OFFSET(0)) u_dut0 (
        .clk_i       (clk),
        .rst_i       (rst),
        .tick_i      (tick0),
        .trigger_i   (trigger0),
        .cancel_i    (cancel0),
        .rnd_i       (rnd0),
        .lfsr_en_o   (lfsr_en0),
        .busy_o      (busy0),
        .time_out_o  (time_out0),
        .delay_val_o (delay_val0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock; outputs are then sampled 1 time unit after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        step();
        vectors++;
        if ({lfsr_en, busy, time_out, delay_val} !== 8'h00) begin
            miscompares++;
            $display("FAIL reset_outputs: got %b want 00000000", {lfsr_en, busy, time_out, delay_val});
        end
        vectors++;
        if ({lfsr_en0, busy0, time_out0, delay_val0} !== 8'h00) begin
            miscompares++;
            $display("FAIL reset_outputs0: got %b want 00000000",
                     {lfsr_en0, busy0, time_out0, delay_val0});
        end
        rst = 1'b0;
        step();
    endtask

    task automatic test_full_delay();
        int to_cnt, to_at, en_cnt;
        logic busy_after;
        to_cnt = 0; to_at = -1; en_cnt = 0; busy_after = 1'b1;
        rnd = 4'hF;
        trigger = 1'b1;
        step();
        vectors++;
        if (delay_val !== 5'd16 || lfsr_en !== 1'b1 || busy !== 1'b1) begin
            miscompares++;
            $display("FAIL full_load: got dv=%0d en=%b busy=%b want dv=16 en=1 busy=1",
                     delay_val, lfsr_en, busy);
        end
        for (int c = 0; c < 70; c++) begin
            tick = (c % 4 == 3);
            step();
            if (lfsr_en) en_cnt++;
            if (time_out) begin
                to_cnt++;
                if (to_at < 0) to_at = c;
            end
            if (c == 64) busy_after = busy;
        end
        tick = 1'b0;
        vectors++;
        if (to_cnt != 1 || to_at != 63) begin
            miscompares++;
            $display("FAIL full_timeout: got %0d pulses at %0d want 1 pulse at 63", to_cnt, to_at);
        end
        vectors++;
        if (en_cnt != 0 || busy_after !== 1'b0) begin
            miscompares++;
            $display("FAIL full_after: got extra_en=%0d busy=%b want 0 0", en_cnt, busy_after);
        end
        trigger = 1'b0;
        step();
    endtask

    task automatic test_held_trigger();
        int busy_seen;
        busy_seen = 0;
        trigger = 1'b1;
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        for (int c = 0; c < 20; c++) begin
            step();
            if (busy) busy_seen++;
        end
        vectors++;
        if (busy_seen != 0) begin
            miscompares++;
            $display("FAIL held_trigger: got %0d busy cycles want 0", busy_seen);
        end
        trigger = 1'b0;
        step();
        trigger = 1'b1;
        rnd = 4'h7;
        step();
        vectors++;
        if (busy !== 1'b1 || delay_val !== 5'd8) begin
            miscompares++;
            $display("FAIL held_restart: got busy=%b dv=%0d want busy=1 dv=8", busy, delay_val);
        end
        cancel = 1'b1;
        step();
        cancel = 1'b0;
        vectors++;
        if (busy !== 1'b0) begin
            miscompares++;
            $display("FAIL held_cancel: got busy=%b want 0", busy);
        end
        trigger = 1'b0;
        step();
    endtask

    task automatic test_tick_high();
        logic [2:0] seen [0:3];
        rnd = 4'h1;
        tick = 1'b1;
        trigger = 1'b1;
        step();
        rnd = 4'hF;
        seen[0] = {busy, time_out, lfsr_en};
        vectors++;
        if (delay_val !== 5'd2) begin
            miscompares++;
            $display("FAIL tick_high_dv: got %0d want 2", delay_val);
        end
        for (int c = 1; c < 4; c++) begin
            step();
            seen[c] = {busy, time_out, lfsr_en};
        end
        vectors++;
        if (seen[0] !== 3'b101 || seen[1] !== 3'b100 || seen[2] !== 3'b110 || seen[3] !== 3'b000) begin
            miscompares++;
            $display("FAIL tick_high_seq: got %b %b %b %b want 101 100 110 000",
                     seen[0], seen[1], seen[2], seen[3]);
        end
        vectors++;
        if (delay_val !== 5'd2) begin
            miscompares++;
            $display("FAIL tick_high_rnd_hold: got %0d want 2", delay_val);
        end
        tick = 1'b0;
        trigger = 1'b0;
        step();
    endtask

    task automatic test_cancel();
        int en_cnt, to_cnt;
        en_cnt = 0; to_cnt = 0;
        rnd = 4'h5;
        trigger = 1'b1;
        step();
        if (lfsr_en) en_cnt++;
        trigger = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick = 1'b1;
            step();
            if (lfsr_en) en_cnt++;
            if (time_out) to_cnt++;
            tick = 1'b0;
            step();
            if (lfsr_en) en_cnt++;
            if (time_out) to_cnt++;
        end
        cancel = 1'b1;
        step();
        cancel = 1'b0;
        vectors++;
        if (busy !== 1'b0 || time_out !== 1'b0) begin
            miscompares++;
            $display("FAIL cancel_now: got busy=%b to=%b want 0 0", busy, time_out);
        end
        tick = 1'b1;
        for (int c = 0; c < 20; c++) begin
            step();
            if (lfsr_en) en_cnt++;
            if (time_out) to_cnt++;
        end
        tick = 1'b0;
        vectors++;
        if (en_cnt != 1 || to_cnt != 0) begin
            miscompares++;
            $display("FAIL cancel_pulses: got en=%0d to=%0d want en=1 to=0", en_cnt, to_cnt);
        end
    endtask

    task automatic test_cancel_final_and_reset();
        rnd = 4'h2;
        trigger = 1'b1;
        step();
        trigger = 1'b0;
        tick = 1'b1;
        step();
        cancel = 1'b1;
        step();
        cancel = 1'b0;
        tick = 1'b0;
        vectors++;
        if (busy !== 1'b0 || time_out !== 1'b0) begin
            miscompares++;
            $display("FAIL cancel_final: got busy=%b to=%b want 0 0", busy, time_out);
        end
        step();
        vectors++;
        if (time_out !== 1'b0) begin
            miscompares++;
            $display("FAIL cancel_final_late: got to=%b want 0", time_out);
        end
        trigger = 1'b1;
        step();
        rst = 1'b1;
        step();
        vectors++;
        if ({lfsr_en, busy, time_out, delay_val} !== 8'h00) begin
            miscompares++;
            $display("FAIL reset_mid_count: got %b want 00000000", {lfsr_en, busy, time_out, delay_val});
        end
        rst = 1'b0;
        trigger = 1'b0;
        step();
    endtask

    task automatic test_offset_zero();
        rnd0 = 4'h3;
        trigger0 = 1'b1;
        step();
        trigger0 = 1'b0;
        step();
        trigger0 = 1'b1;
        step();
        vectors++;
        if (delay_val0 !== 5'd3 || lfsr_en0 !== 1'b0 || busy0 !== 1'b1) begin
            miscompares++;
            $display("FAIL off0_retrigger: got dv=%0d en=%b busy=%b want dv=3 en=0 busy=1",
                     delay_val0, lfsr_en0, busy0);
        end
        cancel0 = 1'b1;
        step();
        cancel0 = 1'b0;
        trigger0 = 1'b0;
        rnd0 = 4'h0;
        step();
        trigger0 = 1'b1;
        step();
        vectors++;
        if (delay_val0 !== 5'd0 || busy0 !== 1'b1 || time_out0 !== 1'b0 || lfsr_en0 !== 1'b1) begin
            miscompares++;
            $display("FAIL off0_load: got dv=%0d busy=%b to=%b en=%b want 0 1 0 1",
                     delay_val0, busy0, time_out0, lfsr_en0);
        end
        step();
        vectors++;
        if (time_out0 !== 1'b1 || busy0 !== 1'b1) begin
            miscompares++;
            $display("FAIL off0_timeout: got to=%b busy=%b want 1 1", time_out0, busy0);
        end
        step();
        vectors++;
        if (time_out0 !== 1'b0 || busy0 !== 1'b0) begin
            miscompares++;
            $display("FAIL off0_idle: got to=%b busy=%b want 0 0", time_out0, busy0);
        end
        trigger0 = 1'b0;
        step();
    endtask

    initial begin
        vectors = 0;
        miscompares = 0;
        rst = 1'b1;
        tick = 1'b0; trigger = 1'b0; cancel = 1'b0; rnd = 4'h0;
        tick0 = 1'b0; trigger0 = 1'b0; cancel0 = 1'b0; rnd0 = 4'h0;
        test_reset();
        test_full_delay();
        test_held_trigger();
        test_tick_high();
        test_cancel();
        test_cancel_final_and_reset();
        test_offset_zero();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
